debouncer_bank: RTL and testbench



---
 rtl/debounce_pkg.sv | 13 +
 rtl/debouncer_bank_if.sv | 24 ++
 rtl/debounce_channel.sv | 96 +++++++++
 rtl/debouncer_bank.sv | 59 +++++
 tb/tb_debouncer_bank.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared defaults and sizing helper for the debouncer bank and its users.
package debounce_pkg;

   localparam int unsigned DEF_N            = 8;
   localparam int unsigned DEF_STABLE_TICKS = 4;
   localparam int unsigned DEF_HOLD_TICKS   = 64;

   // Bits needed to hold every value in 0..max_val inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/debouncer_bank_if.sv
// Pin-side bundle of the debouncer bank: prescaler tap, raw pins and cleaned outputs.
interface debouncer_bank_if #(
   parameter int unsigned N = 8
);

   logic         tick_in;
   logic [N-1:0] raw;
   logic [N-1:0] deb;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic [N-1:0] hold;
   logic         any_deb;

   modport master (
      output tick_in, raw,
      input  deb, rise, fall, hold, any_deb
   );

   modport slave (
      input  tick_in, raw,
      output deb, rise, fall, hold, any_deb
   );

endinterface

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchronizer, stability counter, edge pulses and long-press flag.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_en,
   input  logic i_raw,
   output logic o_deb,
   output logic o_rise,
   output logic o_fall,
   output logic o_hold,
   output logic o_deb_next_c
);

   localparam int unsigned CNT_W  = cnt_width(STABLE_TICKS);
   localparam int unsigned HCNT_W = cnt_width(HOLD_TICKS);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);
   localparam logic [HCNT_W-1:0] HOLD_MAX = HCNT_W'(HOLD_TICKS);

   logic              r_sync1;
   logic              r_sync2;
   logic              r_deb;
   logic              r_rise;
   logic              r_fall;
   logic              r_hold;
   logic [CNT_W-1:0]  r_cnt;
   logic [HCNT_W-1:0] r_hcnt;

   logic              w_accept;
   logic              w_deb_next;
   logic              w_rise_next;
   logic              w_fall_next;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [HCNT_W-1:0] w_hcnt_next;

   // Next-state: a level is accepted only after STABLE_TICKS consecutive differing samples.
   always_comb begin
      w_accept    = i_en && (r_sync2 != r_deb) && (r_cnt == CNT_LAST);
      w_deb_next  = r_deb;
      w_rise_next = 1'b0;
      w_fall_next = 1'b0;
      w_cnt_next  = r_cnt;
      w_hcnt_next = r_hcnt;
      if (i_en) begin
         if (r_sync2 == r_deb) begin
            w_cnt_next = '0;
         end else if (w_accept) begin
            w_deb_next  = r_sync2;
            w_rise_next = r_sync2;
            w_fall_next = ~r_sync2;
            w_cnt_next  = '0;
         end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
         end
         // Either accepted edge restarts the long-press count.
         if (w_accept) begin
            w_hcnt_next = '0;
         end else if (r_deb && (r_hcnt != HOLD_MAX)) begin
            w_hcnt_next = r_hcnt + HCNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_deb   <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_hold  <= 1'b0;
         r_cnt   <= '0;
         r_hcnt  <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_deb   <= w_deb_next;
         r_rise  <= w_rise_next;
         r_fall  <= w_fall_next;
         r_hold  <= (w_hcnt_next == HOLD_MAX);
         r_cnt   <= w_cnt_next;
         r_hcnt  <= w_hcnt_next;
      end
   end

   assign o_deb        = r_deb;
   assign o_rise       = r_rise;
   assign o_fall       = r_fall;
   assign o_hold       = r_hold;
   assign o_deb_next_c = w_deb_next;

endmodule

// File: rtl/debouncer_bank.sv
// Bank of N debouncers sharing one sample strobe taken from the prescaler tap's rising edge.
module debouncer_bank
   import debounce_pkg::*;
#(
   parameter int unsigned N            = DEF_N,
   parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int unsigned HOLD_TICKS   = DEF_HOLD_TICKS
) (
   input  logic            clk,
   input  logic            reset_n,
   debouncer_bank_if.slave bus
);

   logic         r_tick_d;
   logic         r_any_deb;
   logic         w_en;
   logic [N-1:0] w_deb;
   logic [N-1:0] w_rise;
   logic [N-1:0] w_fall;
   logic [N-1:0] w_hold;
   logic [N-1:0] w_deb_next;

   // One-clk strobe per tap period; a frozen tap produces none.
   assign w_en = bus.tick_in & ~r_tick_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tick_d  <= 1'b0;
         r_any_deb <= 1'b0;
      end else begin
         r_tick_d  <= bus.tick_in;
         r_any_deb <= |w_deb_next;
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .HOLD_TICKS   (HOLD_TICKS)
      ) u_ch (
         .clk          (clk),
         .reset_n      (reset_n),
         .i_en         (w_en),
         .i_raw        (bus.raw[gi]),
         .o_deb        (w_deb[gi]),
         .o_rise       (w_rise[gi]),
         .o_fall       (w_fall[gi]),
         .o_hold       (w_hold[gi]),
         .o_deb_next_c (w_deb_next[gi])
      );
   end

   assign bus.deb     = w_deb;
   assign bus.rise    = w_rise;
   assign bus.fall    = w_fall;
   assign bus.hold    = w_hold;
   assign bus.any_deb = r_any_deb;

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed and randomized bench for debouncer_bank against a sample-history reference model.
module tb_debouncer_bank;

   localparam int unsigned NCH  = 4;
   localparam int unsigned ST   = 4;
   localparam int unsigned HOLD = 8;

   logic clk;
   logic reset_n;

   debouncer_bank_if #(.N(NCH)) ifc ();

   debouncer_bank #(
      .N            (NCH),
      .STABLE_TICKS (ST),
      .HOLD_TICKS   (HOLD)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_err;
   int cyc;
   bit frozen;

   // Reference model: a level is accepted once the last ST strobe samples all disagree with it.
   logic [NCH-1:0] m_deb, m_rise, m_fall, m_hold, m_d1, m_d2;
   logic           m_tick_d, m_en;
   logic [ST-1:0]  m_hist [NCH];
   int             m_since [NCH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic smp;
      if (!reset_n) begin
         m_deb = '0; m_rise = '0; m_fall = '0; m_hold = '0;
         m_d1 = '0; m_d2 = '0; m_tick_d = 1'b0; m_en = 1'b0;
         for (int c = 0; c < NCH; c++) begin
            m_hist[c]  = '0;
            m_since[c] = 0;
         end
      end else begin
         m_en   = ifc.tick_in && !m_tick_d;
         m_rise = '0;
         m_fall = '0;
         if (m_en) begin
            for (int c = 0; c < NCH; c++) begin
               smp = m_d2[c];
               m_hist[c] = {m_hist[c][ST-2:0], smp};
               if (m_hist[c] == {ST{~m_deb[c]}}) begin
                  m_deb[c]   = smp;
                  m_rise[c]  = smp;
                  m_fall[c]  = ~smp;
                  m_since[c] = 0;
               end else if (m_deb[c]) begin
                  m_since[c]++;
               end
            end
         end
         for (int c = 0; c < NCH; c++)
            m_hold[c] = m_deb[c] && (m_since[c] >= int'(HOLD));
         m_d2     = m_d1;
         m_d1     = ifc.raw;
         m_tick_d = ifc.tick_in;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      chk("deb",     32'(ifc.deb),     32'(m_deb));
      chk("rise",    32'(ifc.rise),    32'(m_rise));
      chk("fall",    32'(ifc.fall),    32'(m_fall));
      chk("hold",    32'(ifc.hold),    32'(m_hold));
      chk("any_deb", 32'(ifc.any_deb), 32'(|m_deb));
      cyc++;
      if (!frozen) ifc.tick_in = ((cyc / 8) % 2) == 1;
   endtask

   task automatic wait_strobes(input int n);
      int seen;
      int guard;
      seen  = 0;
      guard = 0;
      while (seen < n && guard < n * 40) begin
         step();
         if (m_en) seen++;
         guard++;
      end
      n_checks++;
      assert (seen == n) else begin
         n_err++;
         $error("FAIL strobe_wait: observed=%0d expected=%0d", seen, n);
      end
   endtask

   initial begin
      int len;
      logic [NCH-1:0] mask;
      n_checks    = 0;
      n_err       = 0;
      cyc         = 0;
      frozen      = 1'b0;
      reset_n     = 1'b0;
      ifc.raw     = '0;
      ifc.tick_in = 1'b0;

      // Reset with quiet inputs.
      repeat (5) step();
      chk("rst_deb",  32'(ifc.deb),  32'h0);
      chk("rst_hold", 32'(ifc.hold), 32'h0);
      reset_n = 1'b1;
      wait_strobes(10);
      chk("idle_deb", 32'(ifc.deb), 32'h0);
      chk("idle_any", 32'(ifc.any_deb), 32'h0);

      // Channel 0 press: accepted on the 4th strobe, one-cycle rise.
      ifc.raw[0] = 1'b1;
      wait_strobes(3);
      chk("ch0_early", 32'(ifc.deb[0]), 32'h0);
      wait_strobes(1);
      chk("ch0_deb",  32'(ifc.deb),     32'h1);
      chk("ch0_rise", 32'(ifc.rise),    32'h1);
      chk("ch0_any",  32'(ifc.any_deb), 32'h1);
      step();
      chk("ch0_rise_off", 32'(ifc.rise), 32'h0);

      // Channel 1 glitch restarts the count.
      ifc.raw[1] = 1'b1;
      wait_strobes(3);
      ifc.raw[1] = 1'b0;
      wait_strobes(1);
      ifc.raw[1] = 1'b1;
      wait_strobes(3);
      chk("ch1_restart", 32'(ifc.deb[1]), 32'h0);
      wait_strobes(1);
      chk("ch1_deb",  32'(ifc.deb[1]),  32'h1);
      chk("ch1_rise", 32'(ifc.rise[1]), 32'h1);

      // Channel 2 long press then release.
      ifc.raw[2] = 1'b1;
      wait_strobes(4);
      chk("ch2_deb", 32'(ifc.deb[2]), 32'h1);
      wait_strobes(7);
      chk("ch2_hold_early", 32'(ifc.hold[2]), 32'h0);
      wait_strobes(1);
      chk("ch2_hold", 32'(ifc.hold[2]), 32'h1);
      ifc.raw[2] = 1'b0;
      wait_strobes(3);
      chk("ch2_still", 32'(ifc.deb[2]), 32'h1);
      wait_strobes(1);
      chk("ch2_fall",     32'(ifc.fall),    32'h4);
      chk("ch2_hold_clr", 32'(ifc.hold[2]), 32'h0);
      chk("ch2_deb_clr",  32'(ifc.deb[2]),  32'h0);

      // All channels together, then a frozen tap.
      ifc.raw = '0;
      wait_strobes(4);
      chk("all_low", 32'(ifc.deb), 32'h0);
      ifc.raw = '1;
      wait_strobes(4);
      chk("all_rise", 32'(ifc.rise), 32'hF);
      frozen      = 1'b1;
      ifc.tick_in = 1'b1;
      ifc.raw     = '0;
      repeat (100) step();
      chk("frozen_deb", 32'(ifc.deb), 32'hF);
      frozen = 1'b0;
      wait_strobes(4);
      chk("all_fall", 32'(ifc.fall), 32'hF);

      // Reset mid-count on channel 3 discards progress.
      ifc.raw[3] = 1'b1;
      wait_strobes(2);
      reset_n = 1'b0;
      repeat (12) step();
      chk("mid_rst_deb", 32'(ifc.deb), 32'h0);
      reset_n = 1'b1;
      wait_strobes(3);
      chk("ch3_restart", 32'(ifc.deb[3]), 32'h0);
      wait_strobes(1);
      chk("ch3_rise", 32'(ifc.rise), 32'h8);

      // Random pin activity with glitches of varied width.
      for (int k = 0; k < 60; k++) begin
         mask = NCH'($urandom_range(0, (1 << NCH) - 1));
         if ($urandom_range(0, 2) == 0) ifc.raw = ifc.raw ^ mask;
         else                           ifc.raw = NCH'($urandom);
         len = $urandom_range(1, 90);
         repeat (len) step();
      end
      repeat (200) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
